// File: rtl/de2_pkg.sv
// de2_pkg: shared constants, reset FSM state type and width helper
// for the DE2 key conditioning block.
package de2_pkg;

  localparam int DE2_NKEY        = 4;
  localparam int DE2_CLK_HZ      = 50_000_000;
  localparam int DE2_DEBOUNCE_MS = 20;

  localparam int DE2_DEBOUNCE_CYCLES =
    DE2_CLK_HZ / 1000 * DE2_DEBOUNCE_MS;
  localparam int DE2_RST_HOLD_CYCLES = 16;

  typedef enum logic {
    HOLD,
    RUN
  } de2_rst_state_t;

  function automatic int de2_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/de2_key_debounce.sv
// de2_key_debounce: 2-FF synchronizer plus stability counter for one
// active-low key; stable is the accepted active-high state.
module de2_key_debounce
  import de2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DE2_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable
);

  localparam int CW = de2_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          pressed_sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  assign pressed_sync = ~s2;

  // Any return to agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (pressed_sync == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/de2_key_reset.sv
// de2_key_reset: debounced DE2 keys, press/release events (DE2_KEY_EVENT_EN)
// and a stretched active-high SoC reset driven by KEY[0].
module de2_key_reset
  import de2_pkg::*;
#(
  parameter int NKEY            = DE2_NKEY,
  parameter int DEBOUNCE_CYCLES = DE2_DEBOUNCE_CYCLES,
  parameter int RST_HOLD_CYCLES = DE2_RST_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key_in,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic            soc_rst
);

  localparam int HW = de2_cnt_w(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    de2_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key_in[g]),
      .stable (key_level[g])
    );
  end

`ifdef DE2_KEY_EVENT_EN
  logic [NKEY-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      level_q     <= key_level;
      key_press   <= key_level & ~level_q;
      key_release <= ~key_level & level_q;
    end
  end
`else
  assign key_press   = '0;
  assign key_release = '0;
`endif

  de2_rst_state_t state;
  de2_rst_state_t state_n;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  // A held KEY[0] pins the stretch counter at zero.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    unique case (state)
      HOLD: begin
        if (key_level[0]) begin
          hold_cnt_n = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          state_n    = RUN;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (key_level[0]) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
        end
      end
    endcase
  end

  assign soc_rst = (state == HOLD);

endmodule

// File: tb/tb_de2_key_reset.sv
// tb_de2_key_reset: scoreboard bench; a window-based reference model
// predicts every output each cycle under directed and random key activity.
module tb_de2_key_reset;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int H  = 4;

`ifdef DE2_KEY_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          soc_rst;

  always #5 clk = ~clk;

  de2_key_reset #(
    .NKEY(NK),
    .DEBOUNCE_CYCLES(D),
    .RST_HOLD_CYCLES(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .soc_rst    (soc_rst)
  );

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rls;
    logic          soc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bit            hist[NK][$];
  logic [NK-1:0] m_lvl  = '0;
  logic [NK-1:0] m_prev = '0;
  logic [NK-1:0] m_nl;
  int            idle   = 0;
  bit            all_dis;
  exp_t          m_e;
  exp_t          c_e;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void hist_clear();
    for (int k = 0; k < NK; k++) begin
      hist[k].delete();
      repeat (D + 2) hist[k].push_back(1'b0);
    end
  endfunction

  // Key k flips when the D raw samples ending two edges ago all
  // disagree with its accepted level.
  initial begin
    hist_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        hist_clear();
        m_lvl  = '0;
        m_prev = '0;
        idle   = 0;
        m_e    = '{lvl: '0, prs: '0, rls: '0, soc: 1'b1};
      end else begin
        m_nl = m_lvl;
        for (int k = 0; k < NK; k++) begin
          all_dis = 1'b1;
          for (int j = 1; j <= D; j++)
            if (hist[k][j] == m_lvl[k]) all_dis = 1'b0;
          if (all_dis) m_nl[k] = ~m_lvl[k];
          hist[k].push_back(~key_in[k]);
          void'(hist[k].pop_front());
        end
        if (m_lvl[0]) idle = 0;
        else if (idle < H) idle++;
        m_e.lvl = m_nl;
        m_e.prs = EV ? (m_lvl & ~m_prev) : '0;
        m_e.rls = EV ? (~m_lvl & m_prev) : '0;
        m_e.soc = (idle < H);
        m_prev  = m_lvl;
        m_lvl   = m_nl;
      end
      sb.push_back(m_e);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        c_e = sb.pop_front();
        chk("key_level",   32'(key_level),   32'(c_e.lvl));
        chk("key_press",   32'(key_press),   32'(c_e.prs));
        chk("key_release", 32'(key_release), 32'(c_e.rls));
        chk("soc_rst",     32'(soc_rst),     32'(c_e.soc));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int lat;
  int rem[NK];

  initial begin
    cyc(3);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8);

    cyc(1);
    key_in[2] = 1'b0;
    lat = 0;
    while (key_level[2] !== 1'b1 && lat < 50) begin
      cyc(1);
      lat++;
    end
    chk("press_latency", 32'(lat), 32'(D + 2));
    cyc(5);
    key_in[2] = 1'b1;
    cyc(15);

    key_in[1] = 1'b0; cyc(5);
    key_in[1] = 1'b1; cyc(2);
    key_in[1] = 1'b0; cyc(7);
    key_in[1] = 1'b1; cyc(12);
    key_in[1] = 1'b0; cyc(12);
    key_in[1] = 1'b1; cyc(12);

    key_in[0] = 1'b0; cyc(20);
    key_in[0] = 1'b1; cyc(20);

    key_in[1] = 1'b0;
    key_in[3] = 1'b0;
    cyc(12);
    key_in[1] = 1'b1;
    key_in[3] = 1'b1;
    cyc(12);

    key_in[2] = 1'b0;
    cyc(4);
    do_reset(3);
    cyc(20);
    key_in[2] = 1'b1;
    cyc(14);

    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 14);
    repeat (2000) begin
      cyc(1);
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_in[k] = ~key_in[k];
          rem[k] = $urandom_range(1, 14);
        end else begin
          rem[k]--;
        end
      end
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
    end

    key_in = '1;
    cyc(25);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
